// File: rtl/fifo_uart_tx_reader.sv
// Pops bytes from an 8-bit FIFO and serialises each as one UART frame (8N1).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx_reader #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_rdata_i,
  output logic       fifo_pop_o,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          pop_q, pop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic [2:0]    bit_nxt;

  assign bit_end = (baud_q == BAUD_LAST);
  assign bit_nxt = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = 3'd0;
        tx_d   = 1'b1;
        if (!fifo_empty_i) begin
          // The byte is captured at pop; later FIFO read data is irrelevant.
          state_d = ST_START;
          shift_d = fifo_rdata_i;
          pop_d   = 1'b1;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = ^shift_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset discards any in-flight byte; it has already left the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_pop_o = pop_q;
  assign tx_o       = tx_q;
  assign tx_busy_o  = busy_q;
  assign tx_done_o  = done_q;

endmodule
